// File: rtl/system_controller_pkg.sv
// Shared definitions for the system controller: UART command opcodes, the
// receive-side FSM state encoding and the fixed ALU operand register addresses.
package system_controller_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'hAA;
  localparam logic [7:0] CMD_READ    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPERAND_A_ADDR = 0;
  localparam int OPERAND_B_ADDR = 1;
  localparam int ALU_FUNC_WIDTH = 4;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUNC,
    ALU_WAIT
  } rx_state_e;

  // Maps a command byte to the first state of its sequence; unknown bytes map to IDLE.
  function automatic rx_state_e command_target(input logic [7:0] cmd);
    case (cmd)
      CMD_WRITE:   return WR_ADDR;
      CMD_READ:    return RD_ADDR;
      CMD_ALU_OP:  return OP_A;
      CMD_ALU_NOP: return ALU_FUNC;
      default:     return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_receiver_controller.sv
// Receive-side command sequencer: parses UART frames into register file
// writes/reads and ALU operations. Command bytes are assumed to be 8 bits wide.
module uart_receiver_controller
  import system_controller_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    received_data_synchronized,
  input  logic                     received_data_valid_synchronized,
  input  logic                     enable,
  input  logic                     read_data_valid,
  input  logic                     ALU_result_valid,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     write_enable,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     read_enable,
  output logic [3:0]               ALU_function,
  output logic                     ALU_enable
);

  rx_state_e                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_latch_q, addr_latch_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_enable_q, write_enable_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     read_enable_q, read_enable_d;
  logic [3:0]               alu_function_q, alu_function_d;
  logic                     alu_enable_q, alu_enable_d;

  logic                     frame_valid;
  logic [DATA_WIDTH-1:0]    frame;

  assign frame_valid = received_data_valid_synchronized;
  assign frame       = received_data_synchronized;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_latch_q   <= '0;
      address_q      <= '0;
      write_enable_q <= 1'b0;
      write_data_q   <= '0;
      read_enable_q  <= 1'b0;
      alu_function_q <= '0;
      alu_enable_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_latch_q   <= addr_latch_d;
      address_q      <= address_d;
      write_enable_q <= write_enable_d;
      write_data_q   <= write_data_d;
      read_enable_q  <= read_enable_d;
      alu_function_q <= alu_function_d;
      alu_enable_q   <= alu_enable_d;
    end
  end

  // The address output only moves when a strobe is issued, so it holds between commands.
  always_comb begin
    state_d        = state_q;
    addr_latch_d   = addr_latch_q;
    address_d      = address_q;
    write_enable_d = 1'b0;
    write_data_d   = write_data_q;
    read_enable_d  = 1'b0;
    alu_function_d = alu_function_q;
    alu_enable_d   = alu_enable_q;

    case (state_q)
      IDLE: begin
        if (frame_valid && enable) begin
          state_d = command_target(8'(frame));
        end
      end
      WR_ADDR: begin
        if (frame_valid) begin
          addr_latch_d = frame[ADDRESS_WIDTH-1:0];
          state_d      = WR_DATA;
        end
      end
      WR_DATA: begin
        if (frame_valid) begin
          write_enable_d = 1'b1;
          address_d      = addr_latch_q;
          write_data_d   = frame;
          state_d        = IDLE;
        end
      end
      RD_ADDR: begin
        if (frame_valid) begin
          read_enable_d = 1'b1;
          address_d     = frame[ADDRESS_WIDTH-1:0];
          state_d       = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (read_data_valid) begin
          state_d = IDLE;
        end
      end
      OP_A: begin
        if (frame_valid) begin
          write_enable_d = 1'b1;
          address_d      = ADDRESS_WIDTH'(OPERAND_A_ADDR);
          write_data_d   = frame;
          state_d        = OP_B;
        end
      end
      OP_B: begin
        if (frame_valid) begin
          write_enable_d = 1'b1;
          address_d      = ADDRESS_WIDTH'(OPERAND_B_ADDR);
          write_data_d   = frame;
          state_d        = ALU_FUNC;
        end
      end
      ALU_FUNC: begin
        if (frame_valid) begin
          alu_function_d = frame[ALU_FUNC_WIDTH-1:0];
          alu_enable_d   = 1'b1;
          state_d        = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_result_valid) begin
          alu_enable_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign address      = address_q;
  assign write_enable = write_enable_q;
  assign write_data   = write_data_q;
  assign read_enable  = read_enable_q;
  assign ALU_function = alu_function_q;
  assign ALU_enable   = alu_enable_q;

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Self-checking bench for uart_receiver_controller: a cycle-level vector table,
// an asynchronous-reset sequence and randomized commands against a transaction model.
module tb_uart_receiver_controller;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          resetN;
   logic [DW-1:0] rxData;
   logic          rxValid;
   logic          enable;
   logic          readDataValid;
   logic          aluResultValid;
   logic [AW-1:0] address;
   logic          writeEnable;
   logic [DW-1:0] writeData;
   logic          readEnable;
   logic [3:0]    aluFunction;
   logic          aluEnable;

   int checks   = 0;
   int failures = 0;

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   uart_receiver_controller #(
      .DATA_WIDTH(DW),
      .ADDRESS_WIDTH(AW)
   ) dut (
      .clk(clk),
      .reset(resetN),
      .received_data_synchronized(rxData),
      .received_data_valid_synchronized(rxValid),
      .enable(enable),
      .read_data_valid(readDataValid),
      .ALU_result_valid(aluResultValid),
      .address(address),
      .write_enable(writeEnable),
      .write_data(writeData),
      .read_enable(readEnable),
      .ALU_function(aluFunction),
      .ALU_enable(aluEnable)
   );

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       en;
      logic       rdv;
      logic       arv;
      logic [3:0] eAddr;
      logic       eWe;
      logic [7:0] eWd;
      logic       eRe;
      logic [3:0] eFunc;
      logic       eAen;
   } vec_t;

   vec_t vecTable[$];

   function automatic vec_t mkVec(logic v, logic [7:0] d, logic en, logic rdv, logic arv,
                                  logic [3:0] ea, logic ewe, logic [7:0] ewd, logic ere,
                                  logic [3:0] ef, logic eae);
      vec_t r;
      r.valid = v;   r.data = d;   r.en = en;   r.rdv = rdv;   r.arv = arv;
      r.eAddr = ea;  r.eWe = ewe;  r.eWd = ewd; r.eRe = ere;   r.eFunc = ef;  r.eAen = eae;
      return r;
   endfunction

   function automatic logic [18:0] outBus();
      return {address, writeEnable, writeData, readEnable, aluFunction, aluEnable};
   endfunction

   function automatic logic [18:0] expBus(vec_t v);
      return {v.eAddr, v.eWe, v.eWd, v.eRe, v.eFunc, v.eAen};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs on the falling edge and check the registered outputs after the rising edge
   task automatic applyStimulus(input vec_t v, input string name);
      @(negedge clk);
      rxValid        = v.valid;
      rxData         = v.data;
      enable         = v.en;
      readDataValid  = v.rdv;
      aluResultValid = v.arv;
      @(posedge clk);
      #1;
      checkOutput(name, 32'(outBus()), 32'(expBus(v)));
   endtask

   task automatic sendFrame(input logic [7:0] d, input logic en);
      @(negedge clk);
      rxData  = d;
      enable  = en;
      rxValid = 1'b1;
      @(negedge clk);
      rxValid = 1'b0;
      rxData  = 8'($urandom);
      enable  = 1'($urandom);
   endtask

   // Transaction monitor: records each register strobe and each ALU start as a 16-bit event word
   logic [15:0] obsQ[$];
   logic [15:0] expQ[$];
   logic        prevAen = 1'b0;
   bit          overlap = 1'b0;

   always @(negedge clk) begin
      if (writeEnable && readEnable) overlap = 1'b1;
      if (writeEnable) obsQ.push_back({2'd1, 2'd0, address, writeData});
      if (readEnable)  obsQ.push_back({2'd2, 2'd0, address, 8'd0});
      if (aluEnable && !prevAen) obsQ.push_back({2'd3, 2'd0, 8'd0, aluFunction});
      prevAen = aluEnable;
   end

   // Finishes an ALU command: confirm ALU_enable holds until the result pulse, then clears
   task automatic aluFinish(input bit junk);
      int cnt;
      cnt = 0;
      while (!aluEnable && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      if (!aluEnable) begin
         failures++;
         $display("[TB] FAIL aluStartTimeout: ALU_enable=0 after %0d cycles, required 1", cnt);
      end
      if (junk) sendFrame(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput("aluHeld", 32'(aluEnable), 32'd1);
      @(negedge clk);
      aluResultValid = 1'b1;
      @(negedge clk);
      aluResultValid = 1'b0;
      checkOutput("aluCleared", 32'(aluEnable), 32'd0);
   endtask

   initial begin
      logic [7:0] a, b, f, cmd;
      int         kind;
      bit         match;
      logic [7:0] cmds[4];

      cmds[0] = 8'hAA; cmds[1] = 8'hBB; cmds[2] = 8'hCC; cmds[3] = 8'hDD;

      resetN         = 1'b0;
      rxData         = '0;
      rxValid        = 1'b0;
      enable         = 1'b0;
      readDataValid  = 1'b0;
      aluResultValid = 1'b0;

      // Cycle table: inputs for one cycle, then expected {addr,we,wd,re,func,aen} after the edge
      vecTable.push_back(mkVec(1, 8'hAA, 1, 0, 0, 4'h0, 0, 8'h00, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h05, 1, 0, 0, 4'h0, 0, 8'h00, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h3C, 0, 0, 0, 4'h5, 1, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(0, 8'h00, 0, 0, 0, 4'h5, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hAA, 0, 0, 0, 4'h5, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h05, 1, 0, 0, 4'h5, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h55, 1, 0, 0, 4'h5, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h3C, 1, 0, 0, 4'h5, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hBB, 1, 0, 0, 4'h5, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hFA, 1, 0, 0, 4'hA, 0, 8'h3C, 1, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hBB, 1, 0, 0, 4'hA, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hAA, 1, 0, 0, 4'hA, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(0, 8'h00, 0, 1, 0, 4'hA, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hCC, 1, 0, 0, 4'hA, 0, 8'h3C, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h07, 1, 0, 0, 4'h0, 1, 8'h07, 0, 4'h0, 0));
      vecTable.push_back(mkVec(0, 8'h00, 0, 0, 0, 4'h0, 0, 8'h07, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h03, 0, 0, 0, 4'h1, 1, 8'h03, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'h00, 1, 0, 0, 4'h1, 0, 8'h03, 0, 4'h0, 1));
      vecTable.push_back(mkVec(0, 8'h00, 0, 0, 0, 4'h1, 0, 8'h03, 0, 4'h0, 1));
      vecTable.push_back(mkVec(1, 8'hDD, 1, 0, 0, 4'h1, 0, 8'h03, 0, 4'h0, 1));
      vecTable.push_back(mkVec(0, 8'h00, 0, 0, 1, 4'h1, 0, 8'h03, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hDD, 1, 0, 0, 4'h1, 0, 8'h03, 0, 4'h0, 0));
      vecTable.push_back(mkVec(1, 8'hF2, 1, 0, 0, 4'h1, 0, 8'h03, 0, 4'h2, 1));
      vecTable.push_back(mkVec(0, 8'h00, 0, 0, 0, 4'h1, 0, 8'h03, 0, 4'h2, 1));
      vecTable.push_back(mkVec(0, 8'h00, 0, 0, 1, 4'h1, 0, 8'h03, 0, 4'h2, 0));
      vecTable.push_back(mkVec(1, 8'hAA, 1, 0, 0, 4'h1, 0, 8'h03, 0, 4'h2, 0));
      vecTable.push_back(mkVec(1, 8'h05, 1, 0, 0, 4'h1, 0, 8'h03, 0, 4'h2, 0));

      repeat (3) @(negedge clk);
      checkOutput("resetState", 32'(outBus()), 32'd0);
      resetN = 1'b1;

      for (int i = 0; i < vecTable.size(); i++) begin
         applyStimulus(vecTable[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of a write command, before its data frame
      @(negedge clk);
      rxValid = 1'b0;
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("asyncReset", 32'(outBus()), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      applyStimulus(mkVec(1, 8'h3C, 1, 0, 0, 4'h0, 0, 8'h00, 0, 4'h0, 0), "postResetDrop");
      applyStimulus(mkVec(1, 8'h07, 1, 0, 0, 4'h0, 0, 8'h00, 0, 4'h0, 0), "postResetIdle");
      applyStimulus(mkVec(1, 8'hAA, 1, 0, 0, 4'h0, 0, 8'h00, 0, 4'h0, 0), "postResetCmd");
      applyStimulus(mkVec(1, 8'h09, 1, 0, 0, 4'h0, 0, 8'h00, 0, 4'h0, 0), "postResetAddr");
      applyStimulus(mkVec(1, 8'h11, 1, 0, 0, 4'h9, 1, 8'h11, 0, 4'h0, 0), "postResetWrite");
      @(negedge clk);
      rxValid = 1'b0;
      repeat (2) @(negedge clk);

      // Randomized commands against a transaction-level model of expected strobes
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 5);
         a    = 8'($urandom);
         b    = 8'($urandom);
         f    = 8'($urandom);
         obsQ.delete();
         expQ.delete();
         case (kind)
            0: begin
               sendFrame(8'hAA, 1'b1);
               sendFrame(a, 1'($urandom));
               sendFrame(b, 1'($urandom));
               expQ.push_back({2'd1, 2'd0, 4'(a % 8'd16), b});
            end
            1: begin
               sendFrame(8'hBB, 1'b1);
               sendFrame(a, 1'($urandom));
               expQ.push_back({2'd2, 2'd0, 4'(a % 8'd16), 8'd0});
               repeat ($urandom_range(1, 3)) @(negedge clk);
               if ($urandom_range(0, 1) == 1) sendFrame(8'hAA, 1'b1);
               @(negedge clk);
               readDataValid = 1'b1;
               @(negedge clk);
               readDataValid = 1'b0;
            end
            2: begin
               sendFrame(8'hCC, 1'b1);
               sendFrame(a, 1'($urandom));
               sendFrame(b, 1'($urandom));
               sendFrame(f, 1'($urandom));
               expQ.push_back({2'd1, 2'd0, 4'd0, a});
               expQ.push_back({2'd1, 2'd0, 4'd1, b});
               expQ.push_back({2'd3, 2'd0, 8'd0, 4'(f % 8'd16)});
               aluFinish(1'($urandom));
            end
            3: begin
               sendFrame(8'hDD, 1'b1);
               sendFrame(f, 1'($urandom));
               expQ.push_back({2'd3, 2'd0, 8'd0, 4'(f % 8'd16)});
               aluFinish(1'($urandom));
            end
            4: begin
               sendFrame(cmds[$urandom_range(0, 3)], 1'b0);
            end
            default: begin
               cmd = 8'($urandom);
               if (cmd inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) cmd = 8'h00;
               sendFrame(cmd, 1'b1);
            end
         endcase
         repeat (2) @(negedge clk);
         checks++;
         match = (obsQ.size() == expQ.size());
         if (match) begin
            foreach (expQ[k]) if (obsQ[k] !== expQ[k]) match = 1'b0;
         end
         if (!match) begin
            failures++;
            $display("[TB] FAIL randomCmd%0d kind=%0d: events=%0d first=%h, required events=%0d first=%h",
                     n, kind, obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : 16'h0,
                     expQ.size(), (expQ.size() > 0) ? expQ[0] : 16'h0);
         end
      end

      checkOutput("strobeOverlap", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
